memory_stage: RTL and testbench

//  Pipeline stage between execute and writeback: registers execute results, performs data-RAM

---
 rtl/batpu_pkg.sv | 35 +++
 rtl/memory_stage_data_ram.sv | 47 ++++
 rtl/memory_stage.sv | 200 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/batpu_pkg.sv
// rtl/batpu_pkg.sv - shared control-word indices, memory-stage FSM states and address map
package batpu_pkg;

  // Control word layout as produced by decode and carried through execute
  localparam int CTR_REG_WE  = 0;
  localparam int CTR_DST_LO  = 1;
  localparam int CTR_DST_HI  = 2;
  localparam int CTR_MEM2REG = 3;
  localparam int CTR_HLT     = 4;
  localparam int CTR_MEM_RD  = 5;
  localparam int CTR_MEM_WR  = 6;
  localparam int CTR_W       = 7;
  localparam int CTR_WB_W    = 5;

  // Address map: everything at or above IO_BASE_DEFAULT is the I/O port
  localparam int IO_BASE_DEFAULT = 240;
  localparam int IO_ADDR_W       = 4;

  // Memory-stage handshake states (fixed encodings kept for older tools and dumps)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } mem_fsm_t;

  // True when the control word requests any data-memory access
  function automatic logic is_mem_op(input logic [CTR_W-1:0] ctr);
    return ctr[CTR_MEM_RD] | ctr[CTR_MEM_WR];
  endfunction

endpackage

// File: rtl/memory_stage_data_ram.sv
// rtl/memory_stage_data_ram.sv - single-port data RAM with synchronous read and write
module data_ram
  import batpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = IO_BASE_DEFAULT,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read data only changes when a load actually leaves the stage
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  // Storage array: contents survive reset, as a real RAM macro would
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Registered read port, cleared by reset so from_memory starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX->WB memory stage with RAM, stalling I/O req/ack FSM; watchdog under MEM_IO_TIMEOUT_EN
module memory_stage
  import batpu_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int IO_BASE        = IO_BASE_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 async_rst_n,
  input  logic                 clk_en,
  input  logic                 sync_rst,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [DATA_W-1:0]    store_data,
  input  logic [15:0]          inst_in,
  input  logic [CTR_W-1:0]     ctr_word_in,
  output logic [DATA_W-1:0]    from_alu,
  output logic [DATA_W-1:0]    from_memory,
  output logic [15:0]          inst_bus,
  output logic [CTR_WB_W-1:0]  ctr_word_out,
  output logic                 mem_stall,
  output logic                 io_req,
  output logic                 io_we,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0]    io_wdata,
  input  logic [DATA_W-1:0]    io_rdata,
  input  logic                 io_ack,
  output logic                 io_timeout
);

  localparam int RAM_AW = $clog2(IO_BASE);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("memory_stage: TIMEOUT_CYCLES must be within 2..256 for the 8-bit watchdog");
  end
  if (IO_BASE < 2 || IO_BASE > (1 << ADDR_W) || RAM_AW > ADDR_W) begin : g_bad_io_base
    $error("memory_stage: IO_BASE must fit the address space");
  end

  // Input (EX/MEM) registers
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [15:0]       inst_q, inst_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;

  // Load-data source for the instruction that just left, and captured I/O data
  logic              sel_io_q, sel_io_d;
  logic [DATA_W-1:0] io_q, io_d;

  mem_fsm_t state_q, state_d;

  logic [ADDR_W-1:0] addr;
  logic              mem_rd, mem_wr, is_load;
  logic              in_io_range, is_io, advance;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Decode of the held instruction; a read+write combination is treated as a write
  assign addr        = alu_q[ADDR_W-1:0];
  assign mem_rd      = ctr_q[CTR_MEM_RD];
  assign mem_wr      = ctr_q[CTR_MEM_WR];
  assign is_load     = mem_rd & ~mem_wr;
  assign in_io_range = (int'(addr) >= IO_BASE);
  assign is_io       = is_mem_op(ctr_q) & in_io_range;

  // Stall depends only on registered state, so gating clk_en with it cannot loop
  assign mem_stall = ((state_q == IDLE) & is_io) | (state_q == WAIT);
  assign advance   = clk_en & ~mem_stall;

  // RAM is touched only on the edge where its instruction leaves the stage
  assign ram_we = advance & mem_wr & ~in_io_range;
  assign ram_re = advance & is_load & ~in_io_range;

  data_ram #(
    .DATA_W(DATA_W),
    .DEPTH (IO_BASE),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk  (clk),
    .rst_n(async_rst_n),
    .we   (ram_we),
    .re   (ram_re),
    .addr (alu_q[RAM_AW-1:0]),
    .wdata(sdata_q),
    .rdata(ram_rdata)
  );

  // Pipeline register next-state: hold, load inputs, or load a bubble on flush
  always_comb begin
    alu_d    = alu_q;
    sdata_d  = sdata_q;
    inst_d   = inst_q;
    ctr_d    = ctr_q;
    sel_io_d = sel_io_q;
    if (advance) begin
      sel_io_d = is_io;
      if (sync_rst) begin
        alu_d   = '0;
        sdata_d = '0;
        inst_d  = '0;
        ctr_d   = '0;
      end else begin
        alu_d   = alu_result;
        sdata_d = store_data;
        inst_d  = inst_in;
        ctr_d   = ctr_word_in;
      end
    end
  end

`ifdef MEM_IO_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       io_timeout_q, io_timeout_d;
`endif

  // I/O handshake FSM; runs every cycle regardless of clk_en
  always_comb begin
    state_d = state_q;
    io_d    = io_q;
`ifdef MEM_IO_TIMEOUT_EN
    io_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (is_io) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (io_ack) begin
          state_d = DONE;
          io_d    = io_rdata;
`ifdef MEM_IO_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d      = DONE;
          io_d         = {DATA_W{1'b1}};
          io_timeout_d = 1'b1;
`endif
        end
      end
      DONE: begin
        if (advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_IO_TIMEOUT_EN
    cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + 8'd1 : 8'd0;
`endif
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      alu_q    <= '0;
      sdata_q  <= '0;
      inst_q   <= '0;
      ctr_q    <= '0;
      sel_io_q <= 1'b0;
      io_q     <= '0;
      state_q  <= IDLE;
`ifdef MEM_IO_TIMEOUT_EN
      cnt_q        <= '0;
      io_timeout_q <= 1'b0;
`endif
    end else begin
      alu_q    <= alu_d;
      sdata_q  <= sdata_d;
      inst_q   <= inst_d;
      ctr_q    <= ctr_d;
      sel_io_q <= sel_io_d;
      io_q     <= io_d;
      state_q  <= state_d;
`ifdef MEM_IO_TIMEOUT_EN
      cnt_q        <= cnt_d;
      io_timeout_q <= io_timeout_d;
`endif
    end
  end

`ifdef MEM_IO_TIMEOUT_EN
  assign io_timeout = io_timeout_q;
`else
  assign io_timeout = 1'b0;
`endif

  assign from_alu     = alu_q;
  assign inst_bus     = inst_q;
  assign ctr_word_out = ctr_q[CTR_WB_W-1:0];
  assign from_memory  = sel_io_q ? io_q : ram_rdata;

  // The port sees the held instruction for the whole request
  assign io_req   = (state_q == WAIT);
  assign io_we    = io_req & mem_wr;
  assign io_addr  = IO_ADDR_W'(addr - ADDR_W'(IO_BASE));
  assign io_wdata = sdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized and directed bench for memory_stage against a behavioural model
module tb_memory_stage;

  localparam int TMO = 64;
  localparam logic [6:0] CT_ALU = 7'b0000001;
  localparam logic [6:0] CT_ST  = 7'b1000000;
  localparam logic [6:0] CT_LD  = 7'b0101001;

  typedef struct packed {
    logic [7:0]  alu;
    logic [7:0]  sdata;
    logic [6:0]  ctr;
    logic [15:0] inst;
    logic [31:0] ack_k;   // io_ack on this io_req cycle (1-based); 0 = never
    logic [7:0]  io_val;
  } instr_t;

  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        sync_rst = 1'b0;
  logic [7:0]  alu_result = '0;
  logic [7:0]  store_data = '0;
  logic [15:0] inst_in = '0;
  logic [6:0]  ctr_word_in = '0;
  logic [7:0]  from_alu, from_memory, io_wdata;
  logic [15:0] inst_bus;
  logic [4:0]  ctr_word_out;
  logic        mem_stall, io_req, io_we, io_timeout;
  logic [3:0]  io_addr;
  logic [7:0]  io_rdata = '0;
  logic        io_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_m [240];
  instr_t     held;

  memory_stage dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .sync_rst    (sync_rst),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .inst_in     (inst_in),
    .ctr_word_in (ctr_word_in),
    .from_alu    (from_alu),
    .from_memory (from_memory),
    .inst_bus    (inst_bus),
    .ctr_word_out(ctr_word_out),
    .mem_stall   (mem_stall),
    .io_req      (io_req),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_ack      (io_ack),
    .io_timeout  (io_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_io_f(input instr_t h);
    return (h.ctr[5] | h.ctr[6]) && (h.alu >= 8'd240);
  endfunction

  function automatic logic is_load_f(input instr_t h);
    return h.ctr[5] & ~h.ctr[6];
  endfunction

  function automatic instr_t mk(input logic [7:0] a, input logic [7:0] d, input logic [6:0] c,
                                input logic [15:0] i, input int k, input logic [7:0] v);
    instr_t r;
    r.alu = a; r.sdata = d; r.ctr = c; r.inst = i; r.ack_k = k; r.io_val = v;
    return r;
  endfunction

  function automatic logic [7:0] ram_addr();
    int a;
    a = $urandom_range(0, 16);
    return (a == 16) ? 8'd17 : 8'(a);
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.alu      = 8'($urandom);
    r.sdata    = 8'($urandom);
    r.inst     = 16'($urandom);
    r.ctr      = {2'b00, 5'($urandom)};
    r.ack_k    = $urandom_range(1, 4);
    r.io_val   = 8'($urandom);
    r.ctr[3]   = 1'b0;
    case ($urandom_range(0, 5))
      1: begin r.ctr[6:5] = 2'b10; r.alu = ram_addr(); end
      2: begin r.ctr[6:5] = 2'b01; r.alu = ram_addr(); r.ctr[3] = 1'b1; end
      3: begin r.ctr[6:5] = 2'b10; r.alu = 8'(240 + $urandom_range(0, 15)); end
      4: begin r.ctr[6:5] = 2'b01; r.alu = 8'(240 + $urandom_range(0, 15)); r.ctr[3] = 1'b1; end
      5: begin r.ctr[6:5] = 2'b11; end
      default: r.ctr[6:5] = 2'b00;
    endcase
    return r;
  endfunction

  // Present x, serve the held instruction's I/O, let x enter, then check both
  task automatic send(input instr_t x, input logic flush);
    int         stalls;
    int         reqc;
    int         exp_stalls;
    logic       h_io;
    logic       h_ld;
    logic [7:0] exp_mem;
    h_io    = is_io_f(held);
    h_ld    = is_load_f(held);
    exp_mem = '0;
    alu_result  = x.alu;
    store_data  = x.sdata;
    inst_in     = x.inst;
    ctr_word_in = x.ctr;
    sync_rst    = flush;
    if (!h_io && $urandom_range(0, 7) == 0) begin
      clk_en = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_inst", inst_bus, held.inst);
      check("hold_alu", from_alu, held.alu);
    end
    clk_en = 1'b1;
    stalls = 0;
    reqc   = 0;
    while (mem_stall === 1'b1 && stalls < 400) begin
      if (io_req === 1'b1) begin
        reqc++;
        if (reqc == 1) begin
          check("io_we", io_we, held.ctr[6]);
          check("io_addr", io_addr, 4'(held.alu - 8'd240));
          check("io_wdata", io_wdata, held.sdata);
        end
        io_ack   = (reqc == int'(held.ack_k));
        io_rdata = io_ack ? held.io_val : 8'($urandom);
      end else begin
        io_ack   = 1'($urandom);
        io_rdata = 8'($urandom);
      end
      stalls++;
      @(negedge clk);
    end
    exp_stalls = !h_io ? 0 : (held.ack_k == 0) ? TMO + 1 : int'(held.ack_k) + 1;
    check("stall_cycles", stalls, exp_stalls);
    check("io_timeout", io_timeout, h_io && held.ack_k == 0);
    io_ack   = 1'($urandom);
    io_rdata = 8'($urandom);
    if (h_ld) begin
      if (h_io) exp_mem = (held.ack_k == 0) ? 8'hFF : held.io_val;
      else      exp_mem = ram_m[held.alu];
    end
    if (held.ctr[6] && !h_io) ram_m[held.alu] = held.sdata;
    @(negedge clk);
    io_ack   = 1'b0;
    sync_rst = 1'b0;
    held = flush ? '0 : x;
    check("from_alu", from_alu, held.alu);
    check("inst_bus", inst_bus, held.inst);
    check("ctr_word_out", ctr_word_out, held.ctr[4:0]);
    if (h_ld) check("from_memory", from_memory, exp_mem);
  endtask

  initial begin
    int n;
    held = '0;
    repeat (3) @(negedge clk);
    check("rst_from_alu", from_alu, 0);
    check("rst_from_memory", from_memory, 0);
    check("rst_inst_bus", inst_bus, 0);
    check("rst_ctr_word_out", ctr_word_out, 0);
    check("rst_mem_stall", mem_stall, 0);
    check("rst_io_req", io_req, 0);
    check("rst_io_we", io_we, 0);
    check("rst_io_timeout", io_timeout, 0);
    async_rst_n = 1'b1;
    @(negedge clk);

    // Give every RAM address the loads can pick a known value
    for (int a = 0; a < 18; a++) begin
      if (a != 16) send(mk(8'(a), 8'($urandom), CT_ST, 16'($urandom), 1, 8'h00), 1'b0);
    end

    // Store then back-to-back load of the same address
    send(mk(8'd17, 8'h5A, CT_ST, 16'hA001, 1, 8'h00), 1'b0);
    send(mk(8'd17, 8'h00, CT_LD, 16'hA002, 1, 8'h00), 1'b0);
    send(mk(8'h01, 8'h00, CT_ALU, 16'hA003, 1, 8'h00), 1'b0);
    check("b2b_value", from_memory, 8'h5A);

    // I/O load at 242, ack on the third io_req cycle
    send(mk(8'd242, 8'h00, CT_LD, 16'hB001, 3, 8'h3C), 1'b0);
    send(mk(8'h02, 8'h00, CT_ALU, 16'hB002, 1, 8'h00), 1'b0);

    // I/O store at 250, then RAM load of 10 must be untouched
    send(mk(8'd250, 8'h81, CT_ST, 16'hC001, 1, 8'h00), 1'b0);
    send(mk(8'd10, 8'h00, CT_LD, 16'hC002, 1, 8'h00), 1'b0);
    send(mk(8'h03, 8'h00, CT_ALU, 16'hC003, 1, 8'h00), 1'b0);

    // Flush then an ALU op with no stall
    send(rand_instr(), 1'b1);
    send(mk(8'h7F, 8'h00, CT_ALU, 16'hD001, 1, 8'h00), 1'b0);
    send(mk(8'h04, 8'h00, CT_ALU, 16'hD002, 1, 8'h00), 1'b0);

    // Async reset in the middle of a long I/O wait
    send(mk(8'd244, 8'h00, CT_LD, 16'hE001, 50, 8'h11), 1'b0);
    io_ack = 1'b0;
    n = 0;
    while (io_req !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("pre_abort_io_req", io_req, 1);
    @(negedge clk);
    async_rst_n = 1'b0;
    #1;
    check("abort_io_req", io_req, 0);
    check("abort_mem_stall", mem_stall, 0);
    check("abort_inst_bus", inst_bus, 0);
    clk_en = 1'b0;
    @(negedge clk);
    async_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_abort_io_req", io_req, 0);
    check("post_abort_mem_stall", mem_stall, 0);
    check("post_abort_from_memory", from_memory, 0);
    held = '0;

`ifdef MEM_IO_TIMEOUT_EN
    // No ack: watchdog must abort with 8'hFF
    send(mk(8'd245, 8'h00, CT_LD, 16'hF001, 0, 8'h00), 1'b0);
    send(mk(8'h05, 8'h00, CT_ALU, 16'hF002, 1, 8'h00), 1'b0);
    check("timeout_value", from_memory, 8'hFF);
`endif

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      send(rand_instr(), ($urandom_range(0, 15) == 0));
    end
    send(mk(8'h06, 8'h00, CT_ALU, 16'h0006, 1, 8'h00), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
